// File: rtl/heap_pkg.sv
// Shared heap action codes, error codes and sequencer state encoding.
package heap_pkg;

    localparam logic [7:0]  ACTION_RESET       = 8'd1;
    localparam logic [7:0]  ACTION_SIZE        = 8'd4;
    localparam logic [7:0]  ACTION_GREATER     = 8'd9;
    localparam logic [7:0]  ACTION_MIN         = 8'd1;
    localparam logic [7:0]  ACTION_MAX         = 8'd30;
    localparam logic [31:0] ERR_ILLEGAL_ACTION = 32'h8000_0000;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StStrobe,
        StCapture,
        StRespond
    } heap_state_e;

    function automatic logic action_legal(input logic [7:0] action);
        return (action >= ACTION_MIN) && (action <= ACTION_MAX);
    endfunction

endpackage

// File: rtl/heap_sequencer.sv
// Sequences single heap-memory commands: registers a request, strobes mem_clock,
// captures the heap result and holds it until the consumer takes it.
module heap_sequencer
    import heap_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 2,
    parameter int unsigned INDEX_BITS   = 1,
    parameter int unsigned DATA_BITS    = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [DATA_BITS-1:0]    req_in,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BITS-1:0]    rsp_data,
    output logic [31:0]             rsp_error,
    output logic                    mem_clock,
    output logic [7:0]              mem_action,
    output logic [ADDRESS_BITS-1:0] mem_array,
    output logic [INDEX_BITS-1:0]   mem_index,
    output logic [DATA_BITS-1:0]    mem_in,
    input  logic [DATA_BITS-1:0]    mem_out,
    input  logic [31:0]             mem_error,
    output logic [31:0]             op_count,
    output logic [31:0]             err_count
);

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    heap_state_e             state_q, state_d;
    logic                    init_q, init_d;
    logic                    illegal_q, illegal_d;
    logic                    mem_clock_q, mem_clock_d;
    logic [7:0]              mem_action_q, mem_action_d;
    logic [ADDRESS_BITS-1:0] mem_array_q, mem_array_d;
    logic [INDEX_BITS-1:0]   mem_index_q, mem_index_d;
    logic [DATA_BITS-1:0]    mem_in_q, mem_in_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]    rsp_data_q, rsp_data_d;
    logic [31:0]             rsp_error_q, rsp_error_d;
    logic [31:0]             op_count_q, op_count_d;
    logic [31:0]             err_count_q, err_count_d;

    always_comb begin
        state_d      = state_q;
        init_d       = init_q;
        illegal_d    = illegal_q;
        mem_clock_d  = mem_clock_q;
        mem_action_d = mem_action_q;
        mem_array_d  = mem_array_q;
        mem_index_d  = mem_index_q;
        mem_in_d     = mem_in_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        op_count_d   = op_count_q;
        err_count_d  = err_count_q;

        unique case (state_q)
            StInit: begin
                mem_action_d = ACTION_RESET;
                mem_array_d  = '0;
                mem_index_d  = '0;
                mem_in_d     = '0;
                init_d       = 1'b1;
                illegal_d    = 1'b0;
                state_d      = StStrobe;
            end
            StIdle: begin
                if (req_valid) begin
                    illegal_d = !action_legal(req_action);
                    // Illegal actions leave the heap command untouched.
                    if (action_legal(req_action)) begin
                        mem_action_d = req_action;
                        mem_array_d  = req_array;
                        mem_index_d  = req_index;
                        mem_in_d     = req_in;
                    end
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (illegal_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_error_d = ERR_ILLEGAL_ACTION;
                    err_count_d = sat_inc(err_count_q);
                    illegal_d   = 1'b0;
                    state_d     = StRespond;
                end else begin
                    mem_clock_d = ~mem_clock_q;
                    op_count_d  = sat_inc(op_count_q);
                    state_d     = StCapture;
                end
            end
            StCapture: begin
                if (init_q) begin
                    init_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_out;
                    rsp_error_d = mem_error;
                    if (mem_error != 32'd0) begin
                        err_count_d = sat_inc(err_count_q);
                    end
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StInit;
            init_q       <= 1'b0;
            illegal_q    <= 1'b0;
            mem_clock_q  <= 1'b0;
            mem_action_q <= '0;
            mem_array_q  <= '0;
            mem_index_q  <= '0;
            mem_in_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= '0;
            op_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            illegal_q    <= illegal_d;
            mem_clock_q  <= mem_clock_d;
            mem_action_q <= mem_action_d;
            mem_array_q  <= mem_array_d;
            mem_index_q  <= mem_index_d;
            mem_in_q     <= mem_in_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            op_count_q   <= op_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign mem_clock  = mem_clock_q;
    assign mem_action = mem_action_q;
    assign mem_array  = mem_array_q;
    assign mem_index  = mem_index_q;
    assign mem_in     = mem_in_q;
    assign op_count   = op_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_heap_sequencer.sv
// Directed plus randomized bench for heap_sequencer against a transaction-level model.
module tb_heap_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_action = '0;
    logic [1:0]  req_array = '0;
    logic [0:0]  req_index = '0;
    logic [11:0] req_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_data;
    logic [31:0] rsp_error;
    logic        mem_clock;
    logic [7:0]  mem_action;
    logic [1:0]  mem_array;
    logic [0:0]  mem_index;
    logic [11:0] mem_in;
    logic [11:0] mem_out = '0;
    logic [31:0] mem_error = '0;
    logic [31:0] op_count;
    logic [31:0] err_count;

    heap_sequencer #(
        .ADDRESS_BITS(2),
        .INDEX_BITS  (1),
        .DATA_BITS   (12)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_action(req_action),
        .req_array (req_array),
        .req_index (req_index),
        .req_in    (req_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .mem_clock (mem_clock),
        .mem_action(mem_action),
        .mem_array (mem_array),
        .mem_index (mem_index),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .mem_error (mem_error),
        .op_count  (op_count),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_vec  = 0;
    int n_fail = 0;

    // Transaction-level model of the visible state.
    logic        exp_mclk;
    logic [31:0] exp_op;
    logic [31:0] exp_err;
    logic [7:0]  exp_action;
    logic [1:0]  exp_array;
    logic [0:0]  exp_index;
    logic [11:0] exp_in;
    logic [11:0] exp_data;
    logic [31:0] exp_rerr;
    int          last_accept;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        exp_mclk   = 1'b0;
        exp_op     = 32'd0;
        exp_err    = 32'd0;
        exp_action = 8'd0;
        exp_array  = '0;
        exp_index  = '0;
        exp_in     = '0;
        exp_data   = '0;
        exp_rerr   = '0;
    endtask

    task automatic check_mem(input string tag);
        check({tag, ".mem_action"}, 64'(mem_action), 64'(exp_action));
        check({tag, ".mem_array"},  64'(mem_array),  64'(exp_array));
        check({tag, ".mem_index"},  64'(mem_index),  64'(exp_index));
        check({tag, ".mem_in"},     64'(mem_in),     64'(exp_in));
        check({tag, ".mem_clock"},  64'(mem_clock),  64'(exp_mclk));
    endtask

    task automatic check_reset_values(input string tag);
        model_reset();
        check_mem(tag);
        check({tag, ".req_ready"}, 64'(req_ready), 64'(0));
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, ".rsp_data"},  64'(rsp_data),  64'(0));
        check({tag, ".rsp_error"}, 64'(rsp_error), 64'(0));
        check({tag, ".op_count"},  64'(op_count),  64'(0));
        check({tag, ".err_count"}, 64'(err_count), 64'(0));
    endtask

    // Expects reset to have just been released between edges.
    task automatic init_sequence(input string tag);
        tick();
        exp_action = 8'd1;
        exp_array  = '0;
        exp_index  = '0;
        exp_in     = '0;
        check_mem({tag, ".load"});
        check({tag, ".ready1"}, 64'(req_ready), 64'(0));
        tick();
        exp_mclk = ~exp_mclk;
        exp_op   = exp_op + 1;
        check({tag, ".strobe_clk"}, 64'(mem_clock), 64'(exp_mclk));
        check({tag, ".strobe_op"},  64'(op_count),  64'(exp_op));
        check({tag, ".ready2"},     64'(req_ready), 64'(0));
        tick();
        check({tag, ".ready3"},  64'(req_ready), 64'(1));
        check({tag, ".no_rsp"},  64'(rsp_valid), 64'(0));
        check({tag, ".one_clk"}, 64'(mem_clock), 64'(exp_mclk));
    endtask

    task automatic scramble_req();
        req_action = 8'($urandom);
        req_array  = 2'($urandom);
        req_index  = 1'($urandom);
        req_in     = 12'($urandom);
    endtask

    task automatic do_req(input string tag, input logic [7:0] act, input logic [1:0] arr,
                          input logic [0:0] idx, input logic [11:0] din,
                          input logic [11:0] mout, input logic [31:0] merr,
                          input int delay, input logic check_spacing);
        logic legal;
        int   w;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, ".ready_wait"}, 64'(req_ready), 64'(1));
        legal      = (act >= 8'd1) && (act <= 8'd30);
        req_valid  = 1'b1;
        req_action = act;
        req_array  = arr;
        req_index  = idx;
        req_in     = din;
        mem_out    = mout;
        mem_error  = merr;
        rsp_ready  = (delay == 0);
        tick();
        if (check_spacing) check({tag, ".spacing"}, 64'(cycle - last_accept), 64'(4));
        last_accept = cycle;
        req_valid   = 1'b0;
        scramble_req();
        if (legal) begin
            exp_action = act;
            exp_array  = arr;
            exp_index  = idx;
            exp_in     = din;
        end
        check_mem({tag, ".accept"});
        check({tag, ".busy"}, 64'(req_ready), 64'(0));
        check({tag, ".early_rsp"}, 64'(rsp_valid), 64'(0));
        tick();
        if (legal) begin
            exp_mclk = ~exp_mclk;
            exp_op   = exp_op + 1;
            check({tag, ".strobe_clk"}, 64'(mem_clock), 64'(exp_mclk));
            check({tag, ".strobe_rsp"}, 64'(rsp_valid), 64'(0));
            tick();
            exp_data = mout;
            exp_rerr = merr;
            if (merr != 0) exp_err = exp_err + 1;
        end else begin
            exp_data = '0;
            exp_rerr = 32'h8000_0000;
            exp_err  = exp_err + 1;
        end
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
        check({tag, ".rsp_data"},  64'(rsp_data),  64'(exp_data));
        check({tag, ".rsp_error"}, 64'(rsp_error), 64'(exp_rerr));
        check({tag, ".op_count"},  64'(op_count),  64'(exp_op));
        check({tag, ".err_count"}, 64'(err_count), 64'(exp_err));
        check_mem({tag, ".rsp_mem"});
        for (int i = 0; i < delay; i++) begin
            req_valid = 1'($urandom);
            scramble_req();
            mem_out   = 12'($urandom);
            mem_error = $urandom;
            tick();
            check({tag, ".hold_valid"}, 64'(rsp_valid), 64'(1));
            check({tag, ".hold_data"},  64'(rsp_data),  64'(exp_data));
            check({tag, ".hold_error"}, 64'(rsp_error), 64'(exp_rerr));
            check({tag, ".hold_ready"}, 64'(req_ready), 64'(0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check({tag, ".done_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, ".done_ready"}, 64'(req_ready), 64'(1));
        check_mem({tag, ".done_mem"});
    endtask

    initial begin
        logic [7:0]  act;
        logic [31:0] merr;
        model_reset();
        last_accept = 0;
        req_valid = 1'b1;
        scramble_req();
        repeat (3) tick();
        check_reset_values("reset");
        req_valid = 1'b0;
        reset = 1'b1;
        init_sequence("init");

        do_req("size", 8'd4, 2'd2, 1'd0, 12'd0, 12'd1, 32'd0, 0, 1'b0);
        check("size.op2", 64'(op_count), 64'(2));
        do_req("illegal31", 8'd31, 2'd1, 1'd1, 12'h5a5, 12'h123, 32'd7, 0, 1'b0);
        check("illegal31.err1", 64'(err_count), 64'(1));
        do_req("illegal0", 8'd0, 2'd3, 1'd0, 12'h0ff, 12'h321, 32'd0, 2, 1'b0);
        do_req("hold10", 8'd12, 2'd1, 1'd1, 12'habc, 12'h777, 32'h0000_0010, 10, 1'b0);
        do_req("max30", 8'd30, 2'd3, 1'd1, 12'hfff, 12'h800, 32'd0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            act  = 8'($urandom_range(0, 40));
            merr = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
            do_req("random", act, 2'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
                   merr, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in CAPTURE: accept, strobe, then pull reset.
        do_req("pre_abort", 8'd5, 2'd0, 1'd0, 12'd1, 12'd2, 32'd0, 0, 1'b0);
        req_valid  = 1'b1;
        req_action = 8'd6;
        mem_out    = 12'h3c3;
        tick();
        req_valid = 1'b0;
        tick();
        #1 reset = 1'b0;
        #1 check_reset_values("abort");
        tick();
        check_reset_values("abort_low");
        reset = 1'b1;
        init_sequence("reinit");

        for (int i = 0; i < 100; i++) begin
            do_req("greater", 8'd9, 2'($urandom), 1'($urandom), 12'($urandom),
                   12'($urandom), 32'd0, 0, i > 0);
        end
        check("greater.op101", 64'(op_count), 64'(101));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/heap_sequencer.md
HEAP_SEQUENCER -- requirements
Module: heap_sequencer

Interface
REQ-001 Parameters SHALL be: ADDRESS_BITS, default 2, array-number width; INDEX_BITS, default 1, element-index width; DATA_BITS, default 12, element width.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; all state clears while low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_action  input  8  heap action code, 1..30.
REQ-007 req_array/req_index/req_in  input  ADDRESS_BITS/INDEX_BITS/DATA_BITS  operands.
REQ-008 rsp_valid  output  1  response held.
REQ-009 rsp_ready  input  1  consumer takes response.
REQ-010 rsp_data  output  DATA_BITS  captured heap out.
REQ-011 rsp_error  output  32  captured heap error, or local error code.
REQ-012 mem_clock  output  1  heap memory strobe; toggled once per operation.
REQ-013 mem_action/mem_array/mem_index/mem_in  output  8/ADDRESS_BITS/INDEX_BITS/DATA_BITS  registered heap command.
REQ-014 mem_out  input  DATA_BITS  heap output.
REQ-015 mem_error  input  32  heap error.
REQ-016 op_count  output  32  strobes issued.
REQ-017 err_count  output  32  responses with nonzero rsp_error.

Function
REQ-018 The FSM SHALL have states INIT, IDLE, STROBE, CAPTURE, RESPOND.
REQ-019 After reset release, INIT SHALL load mem_action=1 (Reset) and mem_array/mem_index/mem_in=0, then go to STROBE with an init flag set.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, req_valid&&req_ready at edge N SHALL register the operands onto mem_* and enter STROBE.
REQ-022 At edge N+1, STROBE SHALL invert mem_clock, increment op_count and enter CAPTURE.
REQ-023 At edge N+2, CAPTURE SHALL latch mem_out into rsp_data and mem_error into rsp_error, set rsp_valid=1 and enter RESPOND.
REQ-024 If the init flag is set, CAPTURE SHALL discard the data, leave rsp_valid=0, clear the flag and enter IDLE; the first req_ready=1 is after the third edge following reset release.
REQ-025 In RESPOND, rsp_valid, rsp_data and rsp_error SHALL hold stable until rsp_valid&&rsp_ready; that edge SHALL clear rsp_valid and enter IDLE.
REQ-026 Minimum spacing between accepted requests SHALL be 4 cycles.
REQ-027 An illegal action (req_action 0 or >30) SHALL be accepted, SHALL NOT toggle mem_clock or change mem_*, and SHALL enter RESPOND at edge N+1 with rsp_data=0 and rsp_error=32'h8000_0000.
REQ-028 err_count SHALL increment when rsp_valid rises with rsp_error!=0.
REQ-029 op_count and err_count SHALL saturate at 32'hFFFF_FFFF.
REQ-030 req_* changes outside an accepting edge SHALL have no effect; mem_* SHALL change only on an accepting edge or in INIT.

Reset
REQ-031 While reset=0 the block SHALL be in INIT, with mem_clock=0, mem_action=0, mem_array/mem_index/mem_in=0, rsp_valid=0, rsp_data=0, rsp_error=0, req_ready=0 and both counters=0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no response, and the INIT Reset action SHALL be reissued after release.

Structure
REQ-033 Action codes 1..30, the constant ACTION_MAX=30, the constant ERR_ILLEGAL_ACTION=32'h8000_0000 and the FSM state enum SHALL live in shared package heap_pkg.
REQ-034 The block SHALL be one module with no sub-modules; the counters MAY use a local saturating-increment function.

Verification
REQ-035 Release reset, hold req_valid=0 -> exactly one mem_clock toggle with mem_action=1, no rsp_valid, req_ready=1 by cycle 3.
REQ-036 Request Size (4), array 2, heap model returns 1 -> rsp_valid at N+2, rsp_data=1, rsp_error=0, op_count=2.
REQ-037 Request with action 31 -> no mem_clock toggle, rsp_valid at N+1, rsp_error=32'h8000_0000, err_count=1.
REQ-038 Hold rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0 throughout; raising rsp_ready -> IDLE next edge.
REQ-039 Assert reset during CAPTURE -> all outputs return to their reset values immediately; after release the INIT sequence repeats with counters=0.
REQ-040 Issue 100 back-to-back Greater (9) requests with rsp_ready=1 -> 100 responses, each spaced 4 cycles apart, op_count=101.
